// File: rtl/clock_pkg.sv
// Shared clock constants, hour boundaries, controller state encoding and
// the hour-to-strike-count helper used by the chime logic.
package clock_pkg;

  localparam int SEC_PER_DAY  = 86400;
  localparam int SEC_PER_HOUR = 3600;

  // Seconds-of-day at each full hour, 00:00 .. 23:00.
  localparam int HOUR_SEC [24] = '{
    0,     3600,  7200,  10800, 14400, 18000, 21600, 25200,
    28800, 32400, 36000, 39600, 43200, 46800, 50400, 54000,
    57600, 61200, 64800, 68400, 72000, 75600, 79200, 82800
  };

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHIME_ON  = 3'd1,
    ST_CHIME_OFF = 3'd2,
    ST_RING      = 3'd3,
    ST_SNOOZE    = 3'd4
  } state_t;

  // Strike count for a seconds-of-day value on an hour boundary (12-hour
  // dial, midnight and noon give 12); 0 when not on a boundary. Pure
  // compares against the table, so no divider is built.
  function automatic logic [3:0] hour_strikes(input logic [31:0] sec);
    logic [3:0] r;
    r = 4'd0;
    for (int h = 0; h < 24; h++) begin
      r = (sec == HOUR_SEC[h]) ? ((h % 12 == 0) ? 4'd12 : 4'(h % 12)) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/chime_alarm_ctrl_tone_gen.sv
// Square-wave tone divider. Output is high for HALF cycles then low for
// HALF cycles, starting high on the first enabled cycle. clr restarts the
// phase while en stays high (e.g. a chime handing over to an alarm ring).
module tone_gen
  #(parameter int HALF = 5)
  (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic out
);

  localparam int CW = (2 * HALF > 2) ? $clog2(2 * HALF) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] base;

  // Phase the next output is derived from: zero on a restart.
  always_comb begin
    base = clr ? '0 : cnt;
  end

  // Divider and registered tone output; both cleared whenever disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      cnt <= (base == CW'(2 * HALF - 1)) ? '0 : base + CW'(1);
      out <= (base < CW'(HALF));
    end
  end

endmodule

// File: rtl/chime_alarm_ctrl.sv
// Hourly chime and multi-alarm controller: watches the seconds-of-day on
// each tick, strikes the hour, rings/snoozes alarms, drives the speaker.
module chime_alarm_ctrl
  import clock_pkg::*;
  #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TONE_HZ    = 1000,
  parameter int N_ALARM    = 4,
  parameter int SEC_W      = 17,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  localparam int IW        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
  )
  (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [SEC_W-1:0]   cur_sec,
  input  logic               chime_en,
  input  logic               chime_mode,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [SEC_W-1:0]   wr_sec,
  input  logic               wr_arm,
  input  logic               snooze,
  input  logic               stop,
  output logic               speaker,
  output logic               ringing,
  output logic [IW-1:0]      ring_idx,
  output logic [N_ALARM-1:0] armed
);

  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int RW   = $clog2(RING_SEC + 1);
  localparam int SW   = $clog2(SNOOZE_SEC + 1);

  logic [SEC_W-1:0] alarm_sec [N_ALARM];
  state_t           state, state_n;
  logic [RW-1:0]    ring_cnt;
  logic [SW-1:0]    snz_cnt;
  logic [3:0]       strikes;

  logic             wr_ok, disarm, match, alarm_hit, hour_hit;
  logic [IW-1:0]    match_idx;
  logic [3:0]       hour_str, strikes_load;
  logic             load_ring, reload_ring, dec_ring, load_chime, dec_strikes;
  logic             load_snz, dec_snz, sound_n, restart;

  // Write qualification, disarm-of-active-alarm and event detection.
  always_comb begin
    wr_ok     = wr_en && (32'(wr_sec) < 32'(SEC_PER_DAY)) && (32'(wr_idx) < 32'(N_ALARM));
    disarm    = wr_ok && !wr_arm && (wr_idx == ring_idx);
    match     = 1'b0;
    match_idx = '0;
    // Scan from the top down so the lowest matching index is left standing.
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      match_idx = (armed[i] && (cur_sec == alarm_sec[i])) ? IW'(i) : match_idx;
      match     = match | (armed[i] && (cur_sec == alarm_sec[i]));
    end
    alarm_hit    = tick && match;
    hour_str     = hour_strikes(32'(cur_sec));
    hour_hit     = tick && chime_en && (hour_str != 4'd0);
    strikes_load = chime_mode ? hour_str : 4'd1;
  end

  // Next-state decision and the counter actions that go with it.
  always_comb begin
    state_n     = state;
    load_ring   = 1'b0;
    reload_ring = 1'b0;
    dec_ring    = 1'b0;
    load_chime  = 1'b0;
    dec_strikes = 1'b0;
    load_snz    = 1'b0;
    dec_snz     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alarm_hit) begin
          state_n   = ST_RING;
          load_ring = 1'b1;
        end else if (hour_hit) begin
          state_n    = ST_CHIME_ON;
          load_chime = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CHIME_ON: begin
        if (alarm_hit) begin
          state_n   = ST_RING;
          load_ring = 1'b1;
        end else if (tick) begin
          state_n = ST_CHIME_OFF;
        end else begin
          state_n = ST_CHIME_ON;
        end
      end
      ST_CHIME_OFF: begin
        if (alarm_hit) begin
          state_n   = ST_RING;
          load_ring = 1'b1;
        end else if (tick) begin
          dec_strikes = 1'b1;
          state_n     = (strikes > 4'd1) ? ST_CHIME_ON : ST_IDLE;
        end else begin
          state_n = ST_CHIME_OFF;
        end
      end
      ST_RING: begin
        if (stop || disarm) begin
          state_n = ST_IDLE;
        end else if (snooze) begin
          state_n  = ST_SNOOZE;
          load_snz = 1'b1;
        end else if (tick) begin
          dec_ring = 1'b1;
          state_n  = (ring_cnt <= RW'(1)) ? ST_IDLE : ST_RING;
        end else begin
          state_n = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (stop || disarm) begin
          state_n = ST_IDLE;
        end else if (tick && (snz_cnt <= SW'(1))) begin
          state_n     = ST_RING;
          reload_ring = 1'b1;
        end else if (tick) begin
          dec_snz = 1'b1;
        end else begin
          state_n = ST_SNOOZE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    sound_n = (state_n == ST_CHIME_ON) || (state_n == ST_RING);
    restart = sound_n && (state_n != state);
  end

  // Alarm table: qualified writes only; reset clears every alarm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ALARM; i++) alarm_sec[i] <= '0;
      armed <= '0;
    end else if (wr_ok) begin
      alarm_sec[wr_idx] <= wr_sec;
      armed[wr_idx]     <= wr_arm;
    end else begin
      armed <= armed;
    end
  end

  // Controller FSM with its counters and the registered ringing/index outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ring_idx <= '0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      strikes  <= '0;
      ringing  <= 1'b0;
    end else begin
      state   <= state_n;
      ringing <= (state_n == ST_RING);
      if (load_ring) begin
        ring_idx <= match_idx;
        ring_cnt <= RW'(RING_SEC);
      end else if (reload_ring) begin
        ring_cnt <= RW'(RING_SEC);
      end else if (dec_ring) begin
        ring_cnt <= ring_cnt - RW'(1);
      end else begin
        ring_cnt <= ring_cnt;
      end
      if (load_snz) begin
        snz_cnt <= SW'(SNOOZE_SEC);
      end else if (dec_snz) begin
        snz_cnt <= snz_cnt - SW'(1);
      end else begin
        snz_cnt <= snz_cnt;
      end
      if (load_chime) begin
        strikes <= strikes_load;
      end else if (dec_strikes) begin
        strikes <= strikes - 4'd1;
      end else begin
        strikes <= strikes;
      end
    end
  end

  tone_gen #(.HALF(HALF)) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (sound_n),
    .clr (restart),
    .out (speaker)
  );

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
// Directed bench for chime_alarm_ctrl with hand-computed expectations.
module tb_chime_alarm_ctrl;

  localparam int N_ALARM = 4;
  localparam int IW      = 2;
  localparam int SEC_W   = 17;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               tick = 1'b0;
  logic [SEC_W-1:0]   cur_sec = '0;
  logic               chime_en = 1'b0;
  logic               chime_mode = 1'b0;
  logic               wr_en = 1'b0;
  logic [IW-1:0]      wr_idx = '0;
  logic [SEC_W-1:0]   wr_sec = '0;
  logic               wr_arm = 1'b0;
  logic               snooze = 1'b0;
  logic               stop = 1'b0;
  logic               speaker;
  logic               ringing;
  logic [IW-1:0]      ring_idx;
  logic [N_ALARM-1:0] armed;

  int n_vec = 0;
  int n_err = 0;

  chime_alarm_ctrl #(
    .CLK_HZ(1000), .TONE_HZ(100), .N_ALARM(N_ALARM), .SEC_W(SEC_W),
    .RING_SEC(4), .SNOOZE_SEC(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .cur_sec(cur_sec),
    .chime_en(chime_en), .chime_mode(chime_mode),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_sec(wr_sec), .wr_arm(wr_arm),
    .snooze(snooze), .stop(stop), .speaker(speaker), .ringing(ringing),
    .ring_idx(ring_idx), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, leaving us 1 time unit past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input int s);
    cur_sec = SEC_W'(s);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic wr(input int idx, input int s, input logic arm);
    wr_idx = IW'(idx);
    wr_sec = SEC_W'(s);
    wr_arm = arm;
    wr_en  = 1'b1;
    cyc();
    wr_en  = 1'b0;
  endtask

  // Speaker sampled right after each of n ticks spaced 7 cycles apart.
  task automatic run_ticks(input int start, input int n, output logic [31:0] pat);
    pat = '0;
    for (int k = 0; k < n; k++) begin
      tick_at(start + k);
      pat[k] = speaker;
      repeat (6) cyc();
    end
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp;

    // Reset state
    repeat (3) cyc();
    check_val("rst_speaker", {31'd0, speaker}, 32'd0);
    check_val("rst_ringing", {31'd0, ringing}, 32'd0);
    check_val("rst_ring_idx", {30'd0, ring_idx}, 32'd0);
    check_val("rst_armed", {28'd0, armed}, 32'd0);
    rst = 1'b1;
    cyc();

    // Hourly chime, mode 1 at 15:00 -> 3 strikes then quiet
    chime_en = 1'b1;
    chime_mode = 1'b1;
    run_ticks(54000, 8, pat);
    check_val("chime_15h", pat, 32'h0000_0015);
    // Midnight -> 12 strikes
    run_ticks(0, 26, pat);
    check_val("chime_0h", pat, 32'h0055_5555);
    // Mode 0 -> single strike
    chime_mode = 1'b0;
    run_ticks(3600, 4, pat);
    check_val("chime_mode0", pat, 32'h0000_0001);
    // Chime disabled -> nothing
    chime_en = 1'b0;
    run_ticks(7200, 3, pat);
    check_val("chime_off", pat, 32'h0000_0000);

    // Multi-alarm: idx1 and idx3 both at 3661, lowest wins
    wr(1, 3661, 1'b1);
    wr(3, 3661, 1'b1);
    check_val("armed_1_3", {28'd0, armed}, 32'h0000_000a);
    tick_at(3661);
    check_val("ring_on", {31'd0, ringing}, 32'd1);
    check_val("ring_idx_low", {30'd0, ring_idx}, 32'd1);
    pat = '0;
    exp = '0;
    for (int k = 0; k < 20; k++) begin
      pat[k] = speaker;
      exp[k] = ((k / 5) % 2 == 0);
      cyc();
    end
    check_val("ring_tone", pat, exp);
    tick_at(3662);
    tick_at(3663);
    tick_at(3664);
    check_val("ring_tick3", {31'd0, ringing}, 32'd1);
    tick_at(3665);
    check_val("ring_end", {31'd0, ringing}, 32'd0);
    check_val("ring_end_spk", {31'd0, speaker}, 32'd0);

    // Snooze then re-ring with same index; snooze+stop -> idle
    tick_at(3661);
    cyc();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    check_val("snz_quiet", {31'd0, ringing, speaker}, 32'd0);
    tick_at(3662);
    tick_at(3663);
    check_val("snz_tick2", {31'd0, ringing}, 32'd0);
    tick_at(3664);
    check_val("snz_rering", {30'd0, ringing, speaker}, 32'd3);
    check_val("snz_idx", {30'd0, ring_idx}, 32'd1);
    snooze = 1'b1;
    stop = 1'b1;
    cyc();
    snooze = 1'b0;
    stop = 1'b0;
    check_val("stop_wins", {31'd0, ringing}, 32'd0);
    run_ticks(3665, 4, pat);
    check_val("stop_silent", {31'd0, ringing, pat[3:0]}, 32'd0);
    check_val("armed_kept", {28'd0, armed}, 32'h0000_000a);

    // Alarm over chime at 7200
    wr(1, 3661, 1'b0);
    wr(3, 3661, 1'b0);
    wr(0, 7200, 1'b1);
    chime_en = 1'b1;
    chime_mode = 1'b1;
    tick_at(7200);
    check_val("alm_over_chime", {30'd0, ring_idx, ringing}, 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    tick_at(7201);
    check_val("no_chime_after", {30'd0, ringing, speaker}, 32'd0);
    // Alarm at 7201 aborts a running chime; tone phase restarts
    wr(0, 7200, 1'b0);
    wr(2, 7201, 1'b1);
    check_val("armed_2", {28'd0, armed}, 32'h0000_0004);
    tick_at(7200);
    check_val("chime_start", {30'd0, ringing, speaker}, 32'd1);
    repeat (3) cyc();
    tick_at(7201);
    check_val("abort_ring", {29'd0, ring_idx, ringing}, 32'd5);
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      pat[k] = speaker;
      cyc();
    end
    check_val("abort_tone", pat, 32'h0000_001f);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    tick_at(7202);
    check_val("abort_done", {30'd0, ringing, speaker}, 32'd0);

    // Write edge cases
    chime_en = 1'b0;
    wr(2, 7201, 1'b0);
    tick_at(7201);
    check_val("disarmed_no_ring", {31'd0, ringing}, 32'd0);
    wr(1, 500, 1'b1);
    wr(1, 86400, 1'b0);
    check_val("bad_wr_armed", {28'd0, armed}, 32'h0000_0002);
    tick_at(500);
    check_val("bad_wr_time", {29'd0, ring_idx, ringing}, 32'd3);
    wr(1, 500, 1'b0);
    check_val("disarm_ring", {27'd0, armed, ringing}, 32'd0);

    // Async reset mid-ring
    wr(3, 600, 1'b1);
    tick_at(600);
    check_val("pre_rst_ring", {30'd0, ringing, speaker}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst", {26'd0, armed, ringing, speaker}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chime_alarm_ctrl.md
# chime_alarm_ctrl

Parametrised hourly-chime and multi-alarm controller for the digital clock. It takes the seconds-of-day count and the 1 Hz tick, and holds N programmable alarms with per-alarm arm bits. It strikes the hour (single beep or hour-count strikes), rings alarms with snooze and stop, and drives the speaker with a square-wave tone. It sits between the seconds counter and the speaker pin, alongside the time-convert and display path.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency
- TONE_HZ, 1000, speaker tone frequency; HALF = CLK_HZ/(2*TONE_HZ) cycles per half-period
- N_ALARM, 4, number of alarm channels (≥1); IW = max(1, clog2(N_ALARM))
- SEC_W, 17, width of seconds-of-day
- RING_SEC, 60, alarm ring duration in ticks
- SNOOZE_SEC, 300, snooze duration in ticks

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse per second, synchronous to clk
- cur_sec  in  SEC_W  seconds since midnight, 0..86399, valid in the cycle tick is high
- chime_en  in  1  enables the hourly chime
- chime_mode  in  1  0 = one strike per hour; 1 = strike count = hour mod 12 (0 → 12)
- wr_en  in  1  alarm write strobe
- wr_idx  in  IW  alarm index
- wr_sec  in  SEC_W  alarm time
- wr_arm  in  1  arm bit
- snooze  in  1  debounced one-cycle pulse
- stop  in  1  debounced one-cycle pulse
- speaker  out  1  tone output
- ringing  out  1  high in RING
- ring_idx  out  IW  index of the active or snoozed alarm
- armed  out  N_ALARM  arm bits

## Operation
- Reset values: all alarm_sec = 0, armed = 0, state IDLE, speaker = 0, ringing = 0, ring_idx = 0, all counters = 0.
- Writes:
  - wr_en loads alarm_sec[wr_idx] = wr_sec and armed[wr_idx] = wr_arm on the next edge.
  - A write with wr_sec ≥ 86400 or wr_idx ≥ N_ALARM is ignored entirely.
- Events are evaluated only in cycles where tick = 1.
  - Alarm match: armed[i] && cur_sec == alarm_sec[i]. The lowest matching i wins.
  - Hour event: chime_en && cur_sec is a multiple of 3600. The hour is found by compare against the 24 package constants; no divider.
- States: IDLE, CHIME_ON, CHIME_OFF, RING, SNOOZE.
  - IDLE:
    - Alarm match → RING, latching ring_idx and loading ring_cnt = RING_SEC.
    - Otherwise, hour event → CHIME_ON, loading strikes = 1 (mode 0) or 1..12 (mode 1).
  - CHIME_ON: tone on. The next tick → CHIME_OFF.
  - CHIME_OFF: tone off. The next tick decrements strikes; → CHIME_ON if strikes remain, else → IDLE.
  - Alarm match in either CHIME state aborts the chime → RING.
  - RING: continuous tone, ringing = 1. Each tick decrements ring_cnt; at 0 → IDLE.
    - snooze → SNOOZE with snz_cnt = SNOOZE_SEC.
    - stop → IDLE.
  - SNOOZE: silent. Each tick decrements snz_cnt; at 0 → RING with ring_cnt = RING_SEC and the same ring_idx. stop → IDLE.
- Priorities:
  - stop beats snooze in the same cycle.
  - stop/snooze beat a same-cycle tick decrement.
  - New alarm matches and hour events are ignored in RING and SNOOZE.
- Writing wr_arm = 0 to ring_idx while in RING or SNOOZE → IDLE.
- Stopping an alarm does not disarm it; it fires again the next day.
- Tone:
  - The divider is cleared on every entry to a sounding state.
  - speaker = 1 in the first sounding cycle, then toggles every HALF cycles.
  - speaker = 0 in non-sounding states.

## Timing
- All outputs are registered.
- A tick, stop, snooze or write in cycle t takes effect on the state and outputs in cycle t+1.
- Chime strike: exactly one tick period on, one off.
- Mode 1 at 15:00:00 gives 3 strikes, ending 6 ticks after the hour tick.
- Alarm ring ends after RING_SEC ticks, counting the entry tick as 0.
- Asynchronous reset mid-ring or mid-chime silences the speaker immediately and clears all alarms.

## Structure
- Shared package clock_pkg:
  - SEC_PER_DAY = 86400, SEC_PER_HOUR = 3600
  - the 24 hour-boundary constants
  - the state enum
- Sub-module tone_gen:
  - ports: clk, rst, en, HALF parameter, out
  - free-running divider cleared when en is low

## Test plan
Bench parameters: CLK_HZ = 1000, TONE_HZ = 100 (HALF = 5), N_ALARM = 4, RING_SEC = 4, SNOOZE_SEC = 3.
- Hourly chime, mode 1: tick with cur_sec = 54000 (15:00) → 3 on/off pairs of 1 tick each, then IDLE. Same with cur_sec = 0 → 12 strikes. Mode 0 → 1 strike.
- Multi-alarm: arm idx 1 and idx 3 both at 3661, tick at 3661 → ringing = 1, ring_idx = 1, speaker toggles every 5 cycles starting high. IDLE after 4 ticks.
- Snooze/stop: in RING, pulse snooze → silent for 3 ticks, then RING again with ring_idx unchanged. Pulse snooze and stop together → IDLE. armed stays set.
- Alarm over chime: alarm at 7200 with chime_en = 1 → RING, no chime. An alarm at 7201 during the chime aborts it → RING.
- Write edge cases:
  - wr_sec = 86400 → no change.
  - Disarm the ringing idx → IDLE next cycle.
  - Disarmed alarm at its matching second → no ring.
- Async reset asserted mid-RING → speaker = 0, armed = 0 with no clock edge needed.
